// File: rtl/noc_run_controller_pkg.sv
// noc_run_controller_pkg
// Shared definitions for the NoC experiment sequencer:
//   - phase encodings driven out on the `phase` port
//   - default number of source/sink pairs
//   - width helper for per-cycle handshake popcounts
package noc_run_controller_pkg;

  localparam int DEFAULT_NUM_NODES = 9;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_WARMUP  = 3'd1,
    PH_MEASURE = 3'd2,
    PH_DRAIN   = 3'd3,
    PH_DONE    = 3'd4
  } phase_e;

  // Bits needed to hold a count in the range 0..n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/flit_popcount.sv
// flit_popcount
// Combinational count of local-port handshakes across all nodes in one cycle.
// A handshake on node i is valid[i] & ~busy[i].
// Ports:
//   valid  in  NUM_NODES  per-node valid
//   busy   in  NUM_NODES  per-node busy/backpressure
//   count  out CW         number of handshakes this cycle, 0..NUM_NODES
module flit_popcount
  import noc_run_controller_pkg::*;
#(
  parameter int NUM_NODES = DEFAULT_NUM_NODES,
  parameter int CW        = count_width(NUM_NODES)
) (
  input  logic [NUM_NODES-1:0] valid,
  input  logic [NUM_NODES-1:0] busy,
  output logic [CW-1:0]        count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_NODES; i++) begin
      count = count + CW'(valid[i] & ~busy[i]);
    end
  end

endmodule

// File: rtl/noc_run_controller.sv
// noc_run_controller
// Experiment sequencer for the parallel NoC bench. Steps through
// IDLE/WARMUP/MEASURE/DRAIN/DONE, gates the shared `send` enable with an
// LFSR throttle against PIR, and counts source/sink handshakes.
// Ports:
//   clk              in   sole clock, rising edge
//   reset            in   synchronous, active-high
//   start            in   begin a run (honoured only in IDLE or DONE)
//   src_valid/busy   in   per-source handshake signals
//   sink_valid/busy  in   per-sink handshake signals
//   send             out  injection enable to all sources
//   phase            out  current phase (phase_e encoding)
//   injected_count   out  source handshakes during MEASURE (saturating)
//   delivered_count  out  sink handshakes during MEASURE (saturating)
//   in_flight        out  injected minus delivered since reset, clamped
//   done             out  high while in DONE
//   timeout          out  last DRAIN ended by timeout, not emptiness
//   error            out  sticky: a delivery would have driven in_flight < 0
module noc_run_controller
  import noc_run_controller_pkg::*;
#(
  parameter int NUM_NODES      = DEFAULT_NUM_NODES,
  parameter int PIR            = 255,
  parameter int WARMUP_CYCLES  = 100,
  parameter int MEASURE_CYCLES = 1000,
  parameter int DRAIN_TIMEOUT  = 4096,
  parameter int CNT_W          = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_NODES-1:0] src_valid,
  input  logic [NUM_NODES-1:0] src_busy,
  input  logic [NUM_NODES-1:0] sink_valid,
  input  logic [NUM_NODES-1:0] sink_busy,
  output logic                 send,
  output logic [2:0]           phase,
  output logic [CNT_W-1:0]     injected_count,
  output logic [CNT_W-1:0]     delivered_count,
  output logic [CNT_W-1:0]     in_flight,
  output logic                 done,
  output logic                 timeout,
  output logic                 error
);

  localparam int               PW          = count_width(NUM_NODES);
  localparam logic [7:0]       PIR_THRESH  = 8'(PIR);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [31:0]      WARMUP_LAST = 32'(WARMUP_CYCLES - 1);
  localparam logic [31:0]      MEASURE_LAST = 32'(MEASURE_CYCLES - 1);
  localparam logic [31:0]      DRAIN_LAST  = 32'(DRAIN_TIMEOUT - 1);

  // Zero-length phases are skipped entirely, so resolve the successor
  // states at elaboration time.
  localparam phase_e FIRST_PHASE  = (WARMUP_CYCLES > 0)  ? PH_WARMUP  :
                                    (MEASURE_CYCLES > 0) ? PH_MEASURE : PH_DRAIN;
  localparam phase_e AFTER_WARMUP = (MEASURE_CYCLES > 0) ? PH_MEASURE : PH_DRAIN;

  phase_e           state;
  logic [31:0]      cyc;
  logic [7:0]       lfsr;
  logic [PW-1:0]    n_inj;
  logic [PW-1:0]    n_del;
  logic [CNT_W:0]   inj_sum;
  logic [CNT_W:0]   del_sum;
  logic [CNT_W+1:0] fl_sum;
  logic [CNT_W-1:0] inj_next;
  logic [CNT_W-1:0] del_next;
  logic [CNT_W-1:0] fl_next;
  logic             fl_neg;

  flit_popcount #(.NUM_NODES(NUM_NODES), .CW(PW)) u_src_pop (
    .valid (src_valid),
    .busy  (src_busy),
    .count (n_inj)
  );

  flit_popcount #(.NUM_NODES(NUM_NODES), .CW(PW)) u_sink_pop (
    .valid (sink_valid),
    .busy  (sink_busy),
    .count (n_del)
  );

  // in_flight arithmetic uses two extra bits: the top one is the sign,
  // the next one flags overflow past CNT_MAX.
  always_comb begin
    inj_sum  = {1'b0, injected_count} + (CNT_W+1)'(n_inj);
    del_sum  = {1'b0, delivered_count} + (CNT_W+1)'(n_del);
    inj_next = inj_sum[CNT_W] ? CNT_MAX : inj_sum[CNT_W-1:0];
    del_next = del_sum[CNT_W] ? CNT_MAX : del_sum[CNT_W-1:0];
    fl_sum   = {2'b00, in_flight} + (CNT_W+2)'(n_inj) - (CNT_W+2)'(n_del);
    fl_neg   = fl_sum[CNT_W+1];
    if (fl_neg)            fl_next = '0;
    else if (fl_sum[CNT_W]) fl_next = CNT_MAX;
    else                   fl_next = fl_sum[CNT_W-1:0];
  end

  // The LFSR never holds zero, so PIR=0 never injects and PIR=255 always does.
  assign send  = (lfsr <= PIR_THRESH) && (state == PH_WARMUP || state == PH_MEASURE);
  assign phase = state;
  assign done  = (state == PH_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= PH_IDLE;
      cyc             <= '0;
      lfsr            <= 8'h01;
      injected_count  <= '0;
      delivered_count <= '0;
      in_flight       <= '0;
      timeout         <= 1'b0;
      error           <= 1'b0;
    end else begin
      // Fibonacci taps 8,6,5,4.
      lfsr      <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      in_flight <= fl_next;
      if (fl_neg) error <= 1'b1;

      if (state == PH_MEASURE) begin
        injected_count  <= inj_next;
        delivered_count <= del_next;
      end

      case (state)
        PH_IDLE, PH_DONE: begin
          if (start) begin
            state           <= FIRST_PHASE;
            cyc             <= '0;
            timeout         <= 1'b0;
            injected_count  <= '0;
            delivered_count <= '0;
          end
        end
        PH_WARMUP: begin
          if (cyc == WARMUP_LAST) begin
            state <= AFTER_WARMUP;
            cyc   <= '0;
          end else begin
            cyc <= cyc + 32'd1;
          end
        end
        PH_MEASURE: begin
          if (cyc == MEASURE_LAST) begin
            state <= PH_DRAIN;
            cyc   <= '0;
          end else begin
            cyc <= cyc + 32'd1;
          end
        end
        PH_DRAIN: begin
          // Emptiness is tested first so it wins over a coincident timeout.
          if (in_flight == '0) begin
            state   <= PH_DONE;
            timeout <= 1'b0;
            cyc     <= '0;
          end else if (cyc == DRAIN_LAST) begin
            state   <= PH_DONE;
            timeout <= 1'b1;
            cyc     <= '0;
          end else begin
            cyc <= cyc + 32'd1;
          end
        end
        default: begin
          state <= PH_IDLE;
          cyc   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_run_controller.sv
// tb_noc_run_controller
// Self-checking bench for noc_run_controller. Four instances with different
// parameter sets share the handshake inputs; each has its own start/reset.
//   dut_a: PIR=255, WARMUP=4, MEASURE=8, DRAIN_TIMEOUT=16 (scoreboarded)
//   dut_b: PIR=0,   WARMUP=4, MEASURE=8
//   dut_c: PIR=100, WARMUP=3, MEASURE=6 (reset/replay)
//   dut_d: PIR=255, WARMUP=0, MEASURE=0 (skip straight to DRAIN)
module tb_noc_run_controller;

  localparam int N  = 9;
  localparam int CW = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] src_valid, src_busy, sink_valid, sink_busy;

  logic reset_a, start_a, send_a, done_a, timeout_a, error_a;
  logic reset_b, start_b, send_b, done_b, timeout_b, error_b;
  logic reset_c, start_c, send_c, done_c, timeout_c, error_c;
  logic reset_d, start_d, send_d, done_d, timeout_d, error_d;
  logic [2:0] phase_a, phase_b, phase_c, phase_d;
  logic [CW-1:0] inj_a, del_a, fl_a, inj_b, del_b, fl_b;
  logic [CW-1:0] inj_c, del_c, fl_c, inj_d, del_d, fl_d;

  noc_run_controller #(.NUM_NODES(N), .PIR(255), .WARMUP_CYCLES(4), .MEASURE_CYCLES(8),
                       .DRAIN_TIMEOUT(16), .CNT_W(CW)) dut_a (
    .clk(clk), .reset(reset_a), .start(start_a),
    .src_valid(src_valid), .src_busy(src_busy), .sink_valid(sink_valid), .sink_busy(sink_busy),
    .send(send_a), .phase(phase_a), .injected_count(inj_a), .delivered_count(del_a),
    .in_flight(fl_a), .done(done_a), .timeout(timeout_a), .error(error_a));

  noc_run_controller #(.NUM_NODES(N), .PIR(0), .WARMUP_CYCLES(4), .MEASURE_CYCLES(8),
                       .DRAIN_TIMEOUT(16), .CNT_W(CW)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b),
    .src_valid(src_valid), .src_busy(src_busy), .sink_valid(sink_valid), .sink_busy(sink_busy),
    .send(send_b), .phase(phase_b), .injected_count(inj_b), .delivered_count(del_b),
    .in_flight(fl_b), .done(done_b), .timeout(timeout_b), .error(error_b));

  noc_run_controller #(.NUM_NODES(N), .PIR(100), .WARMUP_CYCLES(3), .MEASURE_CYCLES(6),
                       .DRAIN_TIMEOUT(16), .CNT_W(CW)) dut_c (
    .clk(clk), .reset(reset_c), .start(start_c),
    .src_valid(src_valid), .src_busy(src_busy), .sink_valid(sink_valid), .sink_busy(sink_busy),
    .send(send_c), .phase(phase_c), .injected_count(inj_c), .delivered_count(del_c),
    .in_flight(fl_c), .done(done_c), .timeout(timeout_c), .error(error_c));

  noc_run_controller #(.NUM_NODES(N), .PIR(255), .WARMUP_CYCLES(0), .MEASURE_CYCLES(0),
                       .DRAIN_TIMEOUT(16), .CNT_W(CW)) dut_d (
    .clk(clk), .reset(reset_d), .start(start_d),
    .src_valid(src_valid), .src_busy(src_busy), .sink_valid(sink_valid), .sink_busy(sink_busy),
    .send(send_d), .phase(phase_d), .injected_count(inj_d), .delivered_count(del_d),
    .in_flight(fl_d), .done(done_d), .timeout(timeout_d), .error(error_d));

  int errors = 0;
  int checks = 0;

  // Scoreboard for dut_a: expected register values after each driven cycle.
  typedef struct { int fl; bit er; int inj; int del; } sb_t;
  sb_t sb_q[$];
  int  m_fl, m_inj, m_del;
  bit  m_er;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on dut_a and push the model's expectation for the edge.
  task automatic drive_a(input logic [N-1:0] sv, input logic [N-1:0] sb,
                         input logic [N-1:0] kv, input logic [N-1:0] kb,
                         input bit st, input bit clr, input bit meas);
    int ni, nd, nf;
    sb_t e;
    src_valid = sv; src_busy = sb; sink_valid = kv; sink_busy = kb; start_a = st;
    ni = $countones(sv & ~sb);
    nd = $countones(kv & ~kb);
    if (clr) begin m_inj = 0; m_del = 0; end
    else if (meas) begin m_inj += ni; m_del += nd; end
    nf = m_fl + ni - nd;
    if (nf < 0) begin nf = 0; m_er = 1'b1; end
    m_fl = nf;
    e.fl = m_fl; e.er = m_er; e.inj = m_inj; e.del = m_del;
    sb_q.push_back(e);
    tick();
    start_a = 1'b0;
  endtask

  // Entries queued before this edge belong to it; compare after it settles.
  always @(posedge clk) begin : monitor
    int  n;
    sb_t e;
    n = sb_q.size();
    #2;
    repeat (n) begin
      e = sb_q.pop_front();
      checks += 4;
      if (fl_a !== CW'(e.fl)) begin
        errors++; $display("[TB] FAIL sb_in_flight: got %0d expected %0d", fl_a, e.fl);
      end
      if (error_a !== e.er) begin
        errors++; $display("[TB] FAIL sb_error: got %0b expected %0b", error_a, e.er);
      end
      if (inj_a !== CW'(e.inj)) begin
        errors++; $display("[TB] FAIL sb_injected: got %0d expected %0d", inj_a, e.inj);
      end
      if (del_a !== CW'(e.del)) begin
        errors++; $display("[TB] FAIL sb_delivered: got %0d expected %0d", del_a, e.del);
      end
    end
  end

  task automatic test_reset();
    src_valid = '0; src_busy = '0; sink_valid = '0; sink_busy = '0;
    {start_a, start_b, start_c, start_d} = '0;
    {reset_a, reset_b, reset_c, reset_d} = '1;
    tick(); tick();
    checks += 7;
    if (phase_a !== 3'd0) begin errors++; $display("[TB] FAIL rst_phase: got %0d expected 0", phase_a); end
    if (send_a !== 1'b0) begin errors++; $display("[TB] FAIL rst_send: got %0b expected 0", send_a); end
    if (inj_a !== '0 || del_a !== '0) begin
      errors++; $display("[TB] FAIL rst_counts: got %0d/%0d expected 0/0", inj_a, del_a);
    end
    if (fl_a !== '0) begin errors++; $display("[TB] FAIL rst_in_flight: got %0d expected 0", fl_a); end
    if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL rst_done: got %0b expected 0", done_a); end
    if (timeout_a !== 1'b0) begin errors++; $display("[TB] FAIL rst_timeout: got %0b expected 0", timeout_a); end
    if (error_a !== 1'b0) begin errors++; $display("[TB] FAIL rst_error: got %0b expected 0", error_a); end
    m_fl = 0; m_inj = 0; m_del = 0; m_er = 1'b0;
    reset_a = 1'b0;
  endtask

  task automatic test_window();
    int sends = 0;
    drive_a('1, '0, '1, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 14; i++) begin
      if (send_a) sends++;
      drive_a('1, '0, '1, '0, 1'b0, 1'b0, (i >= 5 && i <= 12));
    end
    checks += 5;
    if (sends != 12) begin errors++; $display("[TB] FAIL win_send_cycles: got %0d expected 12", sends); end
    if (phase_a !== 3'd4) begin errors++; $display("[TB] FAIL win_phase: got %0d expected 4", phase_a); end
    if (done_a !== 1'b1 || timeout_a !== 1'b0) begin
      errors++; $display("[TB] FAIL win_done: got done=%0b timeout=%0b expected 1/0", done_a, timeout_a);
    end
    if (inj_a !== 20'd72) begin errors++; $display("[TB] FAIL win_injected: got %0d expected 72", inj_a); end
    if (send_a !== 1'b0) begin errors++; $display("[TB] FAIL win_send_done: got %0b expected 0", send_a); end
  endtask

  task automatic test_timeout();
    int sends = 0;
    drive_a(9'h01F, '0, '0, '0, 1'b1, 1'b1, 1'b0);
    for (int i = 1; i <= 28; i++) begin
      if (send_a) sends++;
      // A start pulse mid-MEASURE must be ignored.
      drive_a('0, '0, '1, '1, (i == 7), 1'b0, (i >= 5 && i <= 12));
      if (i == 27) begin
        checks++;
        if (phase_a !== 3'd3) begin errors++; $display("[TB] FAIL to_still_drain: got %0d expected 3", phase_a); end
      end
    end
    checks += 4;
    if (sends != 12) begin errors++; $display("[TB] FAIL to_send_cycles: got %0d expected 12", sends); end
    if (phase_a !== 3'd4) begin errors++; $display("[TB] FAIL to_phase: got %0d expected 4", phase_a); end
    if (timeout_a !== 1'b1) begin errors++; $display("[TB] FAIL to_timeout: got %0b expected 1", timeout_a); end
    if (fl_a !== 20'd5) begin errors++; $display("[TB] FAIL to_in_flight: got %0d expected 5", fl_a); end
  endtask

  task automatic test_arith();
    drive_a('0, '0, 9'h007, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (fl_a !== 20'd2) begin errors++; $display("[TB] FAIL ar_deliver3: got %0d expected 2", fl_a); end
    // Three injections and three deliveries, with busy masking the rest.
    drive_a(9'h1FF, 9'h03F, 9'h1FF, 9'h1F8, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (fl_a !== 20'd2) begin errors++; $display("[TB] FAIL ar_balanced: got %0d expected 2", fl_a); end
    if (inj_a !== '0) begin errors++; $display("[TB] FAIL ar_done_hold: got %0d expected 0", inj_a); end
    drive_a('0, '0, 9'h003, '0, 1'b0, 1'b0, 1'b0);
    drive_a('0, '0, 9'h100, '0, 1'b0, 1'b0, 1'b0);
    checks += 2;
    if (fl_a !== '0) begin errors++; $display("[TB] FAIL ar_underflow_clamp: got %0d expected 0", fl_a); end
    if (error_a !== 1'b1) begin errors++; $display("[TB] FAIL ar_error_set: got %0b expected 1", error_a); end
    drive_a('0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (error_a !== 1'b1) begin errors++; $display("[TB] FAIL ar_error_sticky: got %0b expected 1", error_a); end
    tick();
  endtask

  task automatic test_pir_zero();
    int sends = 0;
    src_valid = '0; src_busy = '0; sink_valid = '0; sink_busy = '0;
    reset_b = 1'b0; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      if (send_b) sends++;
      if (i == 13) begin
        checks++;
        if (phase_b !== 3'd3) begin errors++; $display("[TB] FAIL pz_drain: got %0d expected 3", phase_b); end
      end
      if (i == 14) begin
        checks++;
        if (phase_b !== 3'd4) begin errors++; $display("[TB] FAIL pz_done: got %0d expected 4", phase_b); end
      end
      tick();
    end
    checks += 3;
    if (sends != 0) begin errors++; $display("[TB] FAIL pz_send: got %0d expected 0", sends); end
    if (inj_b !== '0 || del_b !== '0 || fl_b !== '0) begin
      errors++; $display("[TB] FAIL pz_counts: got %0d/%0d/%0d expected 0/0/0", inj_b, del_b, fl_b);
    end
    if (timeout_b !== 1'b0 || done_b !== 1'b1) begin
      errors++; $display("[TB] FAIL pz_flags: got timeout=%0b done=%0b expected 0/1", timeout_b, done_b);
    end
  endtask

  task automatic test_reset_replay();
    logic [6:0] run1, run2;
    src_valid = '0; src_busy = '0; sink_valid = '0; sink_busy = '0;
    tick();
    reset_c = 1'b0; start_c = 1'b1;
    tick();
    start_c = 1'b0;
    for (int i = 0; i < 7; i++) begin run1[i] = send_c; tick(); end
    checks++;
    if (phase_c !== 3'd2) begin errors++; $display("[TB] FAIL rr_mid_measure: got %0d expected 2", phase_c); end
    // Reset wins over a same-cycle start.
    reset_c = 1'b1; start_c = 1'b1;
    tick();
    checks += 4;
    if (phase_c !== 3'd0) begin errors++; $display("[TB] FAIL rr_phase: got %0d expected 0", phase_c); end
    if (inj_c !== '0 || del_c !== '0 || fl_c !== '0) begin
      errors++; $display("[TB] FAIL rr_counts: got %0d/%0d/%0d expected 0/0/0", inj_c, del_c, fl_c);
    end
    if (dut_c.lfsr !== 8'h01) begin errors++; $display("[TB] FAIL rr_lfsr: got %h expected 01", dut_c.lfsr); end
    if (send_c !== 1'b0) begin errors++; $display("[TB] FAIL rr_send: got %0b expected 0", send_c); end
    reset_c = 1'b0;
    tick();
    start_c = 1'b0;
    for (int i = 0; i < 7; i++) begin run2[i] = send_c; tick(); end
    checks++;
    if (run2 !== run1) begin errors++; $display("[TB] FAIL rr_replay: got %b expected %b", run2, run1); end
  endtask

  task automatic test_skip();
    src_valid = '0; src_busy = '0; sink_valid = '0; sink_busy = '0;
    reset_d = 1'b0;
    tick();
    start_d = 1'b1;
    tick();
    start_d = 1'b0;
    checks += 2;
    if (phase_d !== 3'd3) begin errors++; $display("[TB] FAIL sk_drain: got %0d expected 3", phase_d); end
    if (send_d !== 1'b0) begin errors++; $display("[TB] FAIL sk_send_drain: got %0b expected 0", send_d); end
    tick();
    checks += 2;
    if (phase_d !== 3'd4 || done_d !== 1'b1) begin
      errors++; $display("[TB] FAIL sk_done: got phase=%0d done=%0b expected 4/1", phase_d, done_d);
    end
    if (send_d !== 1'b0 || timeout_d !== 1'b0) begin
      errors++; $display("[TB] FAIL sk_flags: got send=%0b timeout=%0b expected 0/0", send_d, timeout_d);
    end
  endtask

  initial begin
    test_reset();
    test_window();
    test_timeout();
    test_arith();
    test_pir_zero();
    test_reset_replay();
    test_skip();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
